// File: rtl/bcd_operand_demux.sv
// Serial BCD digit demux: first NDIG digits build operand A, next NDIG build B, then held until acked.
// Optional build macro BCD_DIGIT_SAT_EN: non-BCD digits are stored as 9 instead of their raw value.
module bcd_operand_demux #(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [3:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [4*NDIG-1:0] a_out,
    output logic [4*NDIG-1:0] b_out,
    output logic              ops_valid,
    input  logic              ops_ack,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            xfer;
    logic            last;
    logic            bad_digit;
    logic [3:0]      digit;

    function automatic logic [3:0] store_digit(input logic [3:0] d);
`ifdef BCD_DIGIT_SAT_EN
        return (d > 4'd9) ? 4'd9 : d;
`else
        return d;
`endif
    endfunction

    // Shifting by a full digit keeps this valid for NDIG=1, where the result is just the new digit.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
        logic [W-1:0] t;
        t      = v << 4;
        t[3:0] = d;
        return t;
    endfunction

    assign din_ready = (state != HOLD);
    assign xfer      = din_valid && din_ready;
    assign last      = (cnt == CW'(NDIG - 1));
    assign bad_digit = (din > 4'd9);
    assign digit     = store_digit(din);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOAD_A: if (xfer) begin
                cnt_nxt = last ? '0 : cnt + 1'b1;
                if (last) state_nxt = LOAD_B;
            end
            LOAD_B: if (xfer) begin
                cnt_nxt = last ? '0 : cnt + 1'b1;
                if (last) state_nxt = HOLD;
            end
            HOLD: if (ops_ack) state_nxt = LOAD_A;
            default: begin
                state_nxt = LOAD_A;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            cnt       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            ops_valid <= 1'b0;
            err       <= 1'b0;
        end else if (clear) begin
            state     <= LOAD_A;
            cnt       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            ops_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ops_valid <= (state_nxt == HOLD);
            if (xfer && state == LOAD_A) a_out <= shift_in(a_out, digit);
            if (xfer && state == LOAD_B) b_out <= shift_in(b_out, digit);
            // The first A digit of a frame restarts the sticky error flag.
            if (xfer) begin
                if (state == LOAD_A && cnt == '0) err <= bad_digit;
                else if (bad_digit)               err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_operand_demux.sv
// Bench for bcd_operand_demux: NDIG=2 and NDIG=1 instances share stimulus, checked against a digit-count model.
module tb_bcd_operand_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  din = 4'd0;
    logic        din_valid = 1'b0;
    logic        ops_ack = 1'b0;

    logic        rdy0, ov0, err0;
    logic [7:0]  a0, b0;
    logic        rdy1, ov1, err1;
    logic [3:0]  a1, b1;

    int total = 0;
    int bad   = 0;

    bcd_operand_demux #(.NDIG(2)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .a_out(a0), .b_out(b0), .ops_valid(ov0), .ops_ack(ops_ack), .err(err0)
    );

    bcd_operand_demux #(.NDIG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .a_out(a1), .b_out(b1), .ops_valid(ov1), .ops_ack(ops_ack), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: per operand frame, count accepted digits; digits 0..N-1 go to A, N..2N-1 to B.
    int          nd[2] = '{2, 1};
    int          n[2];
    bit          hold[2];
    logic [31:0] ma[2], mb[2];
    bit          me[2];

    function automatic logic [3:0] model_digit(input logic [3:0] d);
`ifdef BCD_DIGIT_SAT_EN
        return (d > 4'd9) ? 4'd9 : d;
`else
        return d;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            logic [31:0] mask;
            mask = (32'h1 << (4 * nd[i])) - 32'h1;
            if (!rst_n || clear) begin
                n[i] = 0; hold[i] = 1'b0; ma[i] = 0; mb[i] = 0; me[i] = 1'b0;
            end else if (hold[i]) begin
                if (ops_ack) begin hold[i] = 1'b0; n[i] = 0; end
            end else if (din_valid) begin
                if (n[i] < nd[i]) ma[i] = ((ma[i] << 4) | 32'(model_digit(din))) & mask;
                else              mb[i] = ((mb[i] << 4) | 32'(model_digit(din))) & mask;
                if (n[i] == 0)    me[i] = (din > 4'd9);
                else if (din > 4'd9) me[i] = 1'b1;
                n[i]++;
                if (n[i] == 2 * nd[i]) hold[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("rdy0", 32'(rdy0), 32'(!hold[0]));
        chk("a0",   32'(a0),   ma[0]);
        chk("b0",   32'(b0),   mb[0]);
        chk("ov0",  32'(ov0),  32'(hold[0]));
        chk("err0", 32'(err0), 32'(me[0]));
        chk("rdy1", 32'(rdy1), 32'(!hold[1]));
        chk("a1",   32'(a1),   ma[1]);
        chk("b1",   32'(b1),   mb[1]);
        chk("ov1",  32'(ov1),  32'(hold[1]));
        chk("err1", 32'(err1), 32'(me[1]));
    end

    task automatic cyc(input logic v, input logic [3:0] d, input logic ack, input logic clr);
        din_valid = v; din = d; ops_ack = ack; clear = clr;
        @(posedge clk); #1;
        din_valid = 1'b0; ops_ack = 1'b0; clear = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_a0", 32'(a0), 32'h0);
        chk("rst_ov0", 32'(ov0), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_err0", 32'(err0), 32'h0);
        rst_n = 1'b1;
        chk("rst_rdy0", 32'(rdy0), 32'h1);

        // Basic frame
        cyc(1, 4'd4, 0, 0); cyc(1, 4'd2, 0, 0); cyc(1, 4'd1, 0, 0);
        chk("t1_ov_early", 32'(ov0), 32'h0);
        cyc(1, 4'd7, 0, 0);
        chk("t1_a", 32'(a0), 32'h42);
        chk("t1_b", 32'(b0), 32'h17);
        chk("t1_ov", 32'(ov0), 32'h1);
        chk("t1_rdy", 32'(rdy0), 32'h0);
        chk("t1_err", 32'(err0), 32'h0);

        // Digits offered during HOLD are not taken
        repeat (3) cyc(1, 4'd5, 0, 0);
        chk("t2_a_hold", 32'(a0), 32'h42);
        cyc(1, 4'd5, 1, 0);
        chk("t2_ov_ack", 32'(ov0), 32'h0);
        chk("t2_rdy_ack", 32'(rdy0), 32'h1);
        cyc(1, 4'd5, 0, 0);
        chk("t2_a_first", 32'(a0), 32'h25);
        cyc(0, 4'd0, 0, 1);

        // Invalid digit and sticky error
        cyc(1, 4'd3, 0, 0); cyc(1, 4'hC, 0, 0);
        chk("t3_err_set", 32'(err0), 32'h1);
        cyc(1, 4'd0, 0, 0); cyc(1, 4'd1, 0, 0);
`ifdef BCD_DIGIT_SAT_EN
        chk("t3_a", 32'(a0), 32'h39);
`else
        chk("t3_a", 32'(a0), 32'h3C);
`endif
        repeat (2) cyc(0, 4'd0, 0, 0);
        chk("t3_err_hold", 32'(err0), 32'h1);
        cyc(0, 4'd0, 1, 0);
        cyc(1, 4'd2, 0, 0);
        chk("t3_err_clr", 32'(err0), 32'h0);
        repeat (3) cyc(1, 4'd2, 0, 0);
        cyc(0, 4'd0, 1, 0);

        // CLEAR mid-frame discards the presented digit
        cyc(1, 4'd9, 0, 0); cyc(1, 4'd8, 0, 0); cyc(1, 4'd7, 0, 0);
        cyc(1, 4'd6, 1, 1);
        chk("t4_a_clr", 32'(a0), 32'h0);
        chk("t4_b_clr", 32'(b0), 32'h0);
        chk("t4_rdy", 32'(rdy0), 32'h1);
        cyc(1, 4'd1, 0, 0); cyc(1, 4'd2, 0, 0); cyc(1, 4'd3, 0, 0); cyc(1, 4'd4, 0, 0);
        chk("t4_a", 32'(a0), 32'h12);
        chk("t4_b", 32'(b0), 32'h34);
        cyc(0, 4'd0, 1, 0);

        // Asynchronous reset in HOLD
        repeat (4) cyc(1, 4'd5, 0, 0);
        chk("t5_ov", 32'(ov0), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ov_rst", 32'(ov0), 32'h0);
        chk("t5_a_rst", 32'(a0), 32'h0);
        chk("t5_b_rst", 32'(b0), 32'h0);
        chk("t5_err_rst", 32'(err0), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_rdy", 32'(rdy0), 32'h1);

        // Single-digit operands
        cyc(1, 4'd8, 0, 0);
        chk("t6_ov_early", 32'(ov1), 32'h0);
        cyc(1, 4'd3, 0, 0);
        chk("t6_a", 32'(a1), 32'h8);
        chk("t6_b", 32'(b1), 32'h3);
        chk("t6_ov", 32'(ov1), 32'h1);
        cyc(0, 4'd0, 1, 0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            ops_ack   = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 99) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; din_valid = 1'b0; ops_ack = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
